l2_bank_responder: RTL and testbench
====================================

L2_BANK_RESPONDER -- requirements
Module: l2_bank_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, request byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, data width; parameter BE_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-003 SHALL have parameter ID_WIDTH, default 9, one-hot initiator ID width.
REQ-004 SHALL have parameter MEM_ADDR_WIDTH, default 14, SRAM word-address width; parameter BASE_ADDR, default 32'h1C00_0000, bank base.
REQ-005 SHALL have parameter MEM_LATENCY, default 1, legal range 1..3, SRAM read latency in cycles.
REQ-006 Ports: clk in 1 clock; rst in 1 reset, with one clock, asynchronous active-high reset.
REQ-007 Ports: data_req_i in 1; data_add_i in ADDR_WIDTH; data_wen_i in 1 (1=read, 0=write); data_wdata_i in DATA_WIDTH; data_be_i in BE_WIDTH; data_ID_i in ID_WIDTH; data_gnt_o out 1.
REQ-008 Ports: data_r_valid_o out 1; data_r_ID_o out ID_WIDTH; data_r_rdata_o out DATA_WIDTH; data_r_opc_o out 1 (1=error).
REQ-009 Ports: mem_cen_o out 1 (active low); mem_wen_o out 1 (active low); mem_addr_o out MEM_ADDR_WIDTH; mem_wdata_o out DATA_WIDTH; mem_be_o out BE_WIDTH; mem_rdata_i in DATA_WIDTH.
REQ-010 Ports: sleep_req_i in 1, level request to quiesce; sleep_ack_o out 1, bank idle and not granting.

Function
REQ-011 FSM states ACTIVE, DRAIN, SLEEP; reset state ACTIVE.
REQ-012 ACTIVE: data_gnt_o = data_req_i combinationally; every granted request is accepted the same cycle.
REQ-013 In-range check: BASE_ADDR <= data_add_i < BASE_ADDR + 2**MEM_ADDR_WIDTH * BE_WIDTH.
REQ-014 Accepted in-range request: mem_cen_o=0, mem_wen_o=data_wen_i, mem_addr_o=(data_add_i-BASE_ADDR)>>log2(BE_WIDTH), mem_wdata_o=data_wdata_i, mem_be_o=data_be_i, same cycle.
REQ-015 Accepted out-of-range request: mem_cen_o stays 1; response carries data_r_opc_o=1, data_r_rdata_o=0.
REQ-016 Every accepted request (read or write) yields exactly one response exactly MEM_LATENCY cycles after acceptance, data_r_valid_o=1 for one cycle, data_r_ID_o = accepted ID.
REQ-017 Read in-range response: data_r_rdata_o=mem_rdata_i sampled in response cycle, opc=0; write response: rdata=0, opc=0.
REQ-018 Throughput one request per cycle; back-to-back responses in consecutive cycles, in order.
REQ-019 When no response is due: data_r_valid_o=0, data_r_ID_o=0, data_r_rdata_o=0, data_r_opc_o=0.
REQ-020 Idle: mem_cen_o=1, mem_wen_o=1, other mem outputs 0.
REQ-021 ACTIVE -> DRAIN when sleep_req_i=1; request in that same cycle is NOT granted.
REQ-022 DRAIN: data_gnt_o=0; in-flight responses complete; -> SLEEP when pipeline empty; -> ACTIVE if sleep_req_i drops first.
REQ-023 SLEEP: data_gnt_o=0, mem_cen_o=1, sleep_ack_o=1; -> ACTIVE the cycle after sleep_req_i=0; sleep_ack_o=0 in all other states.
REQ-024 If pipeline already empty on sleep_req_i rise, DRAIN lasts exactly one cycle.

Reset
REQ-025 On rst=1 asynchronously: state ACTIVE, pipeline cleared, all responses suppressed, sleep_ack_o=0, mem_cen_o=1, mem_wen_o=1.
REQ-026 Reset mid-operation discards in-flight responses; none emitted after rst deasserts.
REQ-027 data_gnt_o SHALL be 0 while rst=1.

Structure
REQ-028 Package l2_resp_pkg SHALL hold FSM state enum, OPC_OK/OPC_ERR constants, MEM_LATENCY bounds.
REQ-029 Sub-module l2_resp_pipe SHALL implement MEM_LATENCY-deep valid/ID/is_read/err shift register with empty flag.
REQ-030 Elaboration SHALL fail if MEM_LATENCY outside 1..3 or BE_WIDTH not a power of two.

Verification
REQ-031 MEM_LATENCY=1: write 0x1C00_0008 data 0xA5A5, ID 9'h004; read same, ID 9'h010 -> mem_addr=1 both; responses cycles +1,+2, read rdata=0xA5A5, IDs match, opc=0.
REQ-032 MEM_LATENCY=3: 8 back-to-back reads IDs 1,2,4..128 -> gnt every cycle; 8 consecutive responses starting cycle +3, in order.
REQ-033 Read 0x1C02_0000 (out of range, MEM_ADDR_WIDTH=14) -> mem_cen_o=1, response opc=1, rdata=0, ID echoed.
REQ-034 MEM_LATENCY=2, two reads in flight, raise sleep_req_i -> gnt=0 immediately, both responses delivered, sleep_ack_o=1 after pipeline empty; drop sleep_req_i -> gnt resumes next cycle.
REQ-035 Assert rst with 2 responses in flight (MEM_LATENCY=3) -> all outputs at reset values immediately; no r_valid after rst release.

Source files
------------

// File: rtl/l2_resp_pkg.sv
// Shared types and constants for the L2 bank responder.
package l2_resp_pkg;
  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_DRAIN,
    ST_SLEEP
  } state_e;

  localparam logic OPC_OK  = 1'b0;
  localparam logic OPC_ERR = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 3;
endpackage

// File: rtl/l2_resp_pipe.sv
// Fixed-depth response tracker: valid/ID/is_read/err shifted per cycle.
module l2_resp_pipe
  import l2_resp_pkg::*;
#(
  parameter int DEPTH    = 1,
  parameter int ID_WIDTH = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [ID_WIDTH-1:0] in_id,
  input  logic                in_read,
  input  logic                in_err,
  output logic                out_valid,
  output logic [ID_WIDTH-1:0] out_id,
  output logic                out_read,
  output logic                out_err,
  output logic                empty
);
  logic [DEPTH-1:0]    valid_q;
  logic [DEPTH-1:0]    read_q;
  logic [DEPTH-1:0]    err_q;
  logic [ID_WIDTH-1:0] id_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      read_q  <= '0;
      err_q   <= {DEPTH{OPC_OK}};
      for (int i = 0; i < DEPTH; i++) id_q[i] <= '0;
    end else begin
      // Payload is zeroed with valid so idle outputs read back as 0.
      valid_q[0] <= in_valid;
      read_q[0]  <= in_valid & in_read;
      err_q[0]   <= in_valid & in_err;
      id_q[0]    <= in_valid ? in_id : '0;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        read_q[i]  <= read_q[i-1];
        err_q[i]   <= err_q[i-1];
        id_q[i]    <= id_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_read  = read_q[DEPTH-1];
  assign out_err   = err_q[DEPTH-1];
  assign out_id    = id_q[DEPTH-1];
  assign empty     = ~|valid_q;
endmodule

// File: rtl/l2_bank_responder.sv
// L2 SRAM bank front end: grants, address decode, fixed-latency
// responses and a sleep handshake that drains in-flight reads.
module l2_bank_responder
  import l2_resp_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 64,
  parameter int          BE_WIDTH       = DATA_WIDTH / 8,
  parameter int          ID_WIDTH       = 9,
  parameter int          MEM_ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR      = 32'h1C00_0000,
  parameter int          MEM_LATENCY    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      data_req_i,
  input  logic [ADDR_WIDTH-1:0]     data_add_i,
  input  logic                      data_wen_i,
  input  logic [DATA_WIDTH-1:0]     data_wdata_i,
  input  logic [BE_WIDTH-1:0]       data_be_i,
  input  logic [ID_WIDTH-1:0]       data_ID_i,
  output logic                      data_gnt_o,
  output logic                      data_r_valid_o,
  output logic [ID_WIDTH-1:0]       data_r_ID_o,
  output logic [DATA_WIDTH-1:0]     data_r_rdata_o,
  output logic                      data_r_opc_o,
  output logic                      mem_cen_o,
  output logic                      mem_wen_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [BE_WIDTH-1:0]       mem_be_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  input  logic                      sleep_req_i,
  output logic                      sleep_ack_o
);
  localparam int BE_SHIFT    = $clog2(BE_WIDTH);
  localparam int RANGE_SHIFT = MEM_ADDR_WIDTH + BE_SHIFT;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  if (MEM_LATENCY < MEM_LAT_MIN || MEM_LATENCY > MEM_LAT_MAX) begin : g_bad_lat
    $error("l2_bank_responder: MEM_LATENCY out of range");
  end
  if (BE_WIDTH < 1 || (BE_WIDTH & (BE_WIDTH - 1)) != 0) begin : g_bad_be
    $error("l2_bank_responder: BE_WIDTH must be a power of two");
  end

  state_e state_q, state_d;
  logic                  accept, in_range, hit;
  logic                  pipe_empty, rsp_valid, rsp_read, rsp_err;
  logic [ID_WIDTH-1:0]   rsp_id;
  logic [ADDR_WIDTH-1:0] offset;

  assign offset   = data_add_i - BASE;
  assign in_range = (data_add_i >= BASE) && ((offset >> RANGE_SHIFT) == '0);

  // A request raised together with sleep_req_i is refused.
  assign data_gnt_o = data_req_i & ~rst & ~sleep_req_i
                    & (state_q == ST_ACTIVE);
  assign accept = data_gnt_o;
  assign hit    = accept & in_range;

  assign mem_cen_o   = ~hit;
  assign mem_wen_o   = hit ? data_wen_i : 1'b1;
  assign mem_addr_o  = hit ? MEM_ADDR_WIDTH'(offset >> BE_SHIFT) : '0;
  assign mem_wdata_o = hit ? data_wdata_i : '0;
  assign mem_be_o    = hit ? data_be_i : '0;

  l2_resp_pipe #(
    .DEPTH    (MEM_LATENCY),
    .ID_WIDTH (ID_WIDTH)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_id     (data_ID_i),
    .in_read   (data_wen_i),
    .in_err    (~in_range),
    .out_valid (rsp_valid),
    .out_id    (rsp_id),
    .out_read  (rsp_read),
    .out_err   (rsp_err),
    .empty     (pipe_empty)
  );

  assign data_r_valid_o = rsp_valid;
  assign data_r_ID_o    = rsp_id;
  assign data_r_opc_o   = rsp_err ? OPC_ERR : OPC_OK;
  assign data_r_rdata_o = (rsp_read & ~rsp_err) ? mem_rdata_i : '0;
  assign sleep_ack_o    = (state_q == ST_SLEEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_ACTIVE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACTIVE: if (sleep_req_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!sleep_req_i)    state_d = ST_ACTIVE;
        else if (pipe_empty) state_d = ST_SLEEP;
      end
      ST_SLEEP:  if (!sleep_req_i) state_d = ST_ACTIVE;
      default:   state_d = ST_ACTIVE;
    endcase
  end
endmodule

// File: tb/tb_l2_bank_responder.sv
// Bench: three responders (latency 1..3) against a byte-level memory
// model and an expected-response queue per instance.
module tb_l2_bank_responder;
  localparam longint unsigned BASE  = 64'h1C00_0000;
  localparam longint unsigned LIMIT = BASE + 64'h2_0000;
  localparam int M_ACT = 0, M_DRN = 1, M_SLP = 2;

  typedef struct {
    int          due;
    logic [8:0]  id;
    logic [63:0] data;
    logic        opc;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  logic req [3], wen [3], gnt [3], rv [3], opc [3];
  logic cen [3], mwen [3], sreq [3], sack [3];
  logic [31:0] add [3];
  logic [63:0] wdata [3], rdata [3], mwdata [3];
  logic [7:0]  be [3], mbe [3];
  logic [8:0]  id [3], rid [3];
  logic [13:0] maddr [3];

  rsp_t expq [3][$];
  byte unsigned refmem [longint unsigned];
  int mode [3];
  int now = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [63:0] sram [int unsigned];
    logic [63:0] dl [g+1];

    l2_bank_responder #(.MEM_LATENCY(g + 1)) dut (
      .clk(clk), .rst(rst),
      .data_req_i(req[g]), .data_add_i(add[g]), .data_wen_i(wen[g]),
      .data_wdata_i(wdata[g]), .data_be_i(be[g]), .data_ID_i(id[g]),
      .data_gnt_o(gnt[g]), .data_r_valid_o(rv[g]), .data_r_ID_o(rid[g]),
      .data_r_rdata_o(rdata[g]), .data_r_opc_o(opc[g]),
      .mem_cen_o(cen[g]), .mem_wen_o(mwen[g]), .mem_addr_o(maddr[g]),
      .mem_wdata_o(mwdata[g]), .mem_be_o(mbe[g]), .mem_rdata_i(dl[g]),
      .sleep_req_i(sreq[g]), .sleep_ack_o(sack[g])
    );

    // Behavioural SRAM: fixed read latency, garbage when not reading.
    always @(posedge clk) begin
      logic [63:0] w;
      for (int i = g; i > 0; i--) dl[i] = dl[i-1];
      dl[0] = {$urandom, $urandom};
      if (!cen[g]) begin
        w = sram.exists(maddr[g]) ? sram[maddr[g]] : 64'h0;
        if (mwen[g]) dl[0] = w;
        else begin
          for (int b = 0; b < 8; b++)
            if (mbe[g][b]) w[8*b +: 8] = mwdata[g][8*b +: 8];
          sram[maddr[g]] = w;
        end
      end
    end
  end

  function automatic void chk(string tag, int k, logic [63:0] obs,
                              logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] t=%0d got=%h want=%h", tag, k, now, obs, exp);
    end
  endfunction

  function automatic longint unsigned key(int k, longint unsigned a);
    return (longint'(k) << 40) + a;
  endfunction

  function automatic logic [63:0] ref_read(int k, longint unsigned a);
    logic [63:0] d = '0;
    longint unsigned b0 = key(k, a & ~64'h7);
    for (int b = 0; b < 8; b++)
      if (refmem.exists(b0 + b)) d[8*b +: 8] = refmem[b0 + b];
    return d;
  endfunction

  task automatic check_inst(int k);
    longint unsigned a = 64'(add[k]);
    logic inr, eg, h;
    int inflight;
    rsp_t r;
    if (rst) begin
      expq[k].delete();
      mode[k] = M_ACT;
    end
    inr = (a >= BASE) && (a < LIMIT);
    eg  = !rst && req[k] && !sreq[k] && mode[k] == M_ACT;
    h   = eg && inr;
    chk("gnt", k, gnt[k], eg);
    chk("mem_cen", k, cen[k], !h);
    chk("mem_wen", k, mwen[k], h ? wen[k] : 1'b1);
    chk("mem_addr", k, maddr[k], h ? (a - BASE) / 8 : 0);
    chk("mem_wdata", k, mwdata[k], h ? wdata[k] : 0);
    chk("mem_be", k, mbe[k], h ? be[k] : 0);
    chk("sleep_ack", k, sack[k], !rst && mode[k] == M_SLP);
    inflight = expq[k].size();
    if (inflight > 0 && expq[k][0].due == now) begin
      r = expq[k].pop_front();
      chk("r_valid", k, rv[k], 1);
      chk("r_id", k, rid[k], r.id);
      chk("r_rdata", k, rdata[k], r.data);
      chk("r_opc", k, opc[k], r.opc);
    end else begin
      chk("r_valid", k, rv[k], 0);
      chk("r_id", k, rid[k], 0);
      chk("r_rdata", k, rdata[k], 0);
      chk("r_opc", k, opc[k], 0);
    end
    if (eg) begin
      r.due  = now + k + 1;
      r.id   = id[k];
      r.opc  = !inr;
      r.data = (inr && wen[k]) ? ref_read(k, a) : 64'h0;
      if (inr && !wen[k])
        for (int b = 0; b < 8; b++)
          if (be[k][b]) refmem[key(k, (a & ~64'h7) + b)] = wdata[k][8*b +: 8];
      expq[k].push_back(r);
    end
    if (!rst) begin
      if (!sreq[k]) mode[k] = M_ACT;
      else if (mode[k] == M_ACT) mode[k] = M_DRN;
      else if (mode[k] == M_DRN && inflight == 0) mode[k] = M_SLP;
    end
  endtask

  task automatic tick();
    #2;
    for (int k = 0; k < 3; k++) check_inst(k);
    @(negedge clk);
    now++;
  endtask

  task automatic drive(int k, logic r, logic w, logic [31:0] a,
                       logic [63:0] d, logic [7:0] b, logic [8:0] i);
    req[k] = r; wen[k] = w; add[k] = a;
    wdata[k] = d; be[k] = b; id[k] = i;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) drive(k, 0, 1, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel = $urandom_range(0, 9);
    logic [31:0] edges [4];
    edges[0] = 32'(BASE) - 32'd1;
    edges[1] = 32'(LIMIT) - 32'd1;
    edges[2] = 32'(LIMIT);
    edges[3] = 32'(BASE);
    if (sel < 8) return 32'(BASE) + 32'($urandom_range(0, 31) * 8)
                       + 32'($urandom_range(0, 7));
    return edges[$urandom_range(0, 3)];
  endfunction

  initial begin
    rst = 1'b1;
    idle_all();
    for (int k = 0; k < 3; k++) begin
      sreq[k] = 1'b0;
      mode[k] = M_ACT;
    end
    @(negedge clk);
    req[0] = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle_all();
    tick();

    // Write then read the same word, latency 1.
    drive(0, 1, 0, 32'h1C00_0008, 64'hA5A5, 8'hFF, 9'h004);
    tick();
    drive(0, 1, 1, 32'h1C00_0008, 64'h0, 8'hFF, 9'h010);
    tick();
    idle_all();
    repeat (3) tick();

    // Preload then 8 back-to-back reads, latency 3.
    for (int i = 0; i < 8; i++) begin
      drive(2, 1, 0, 32'(BASE) + 32'(i * 8), {$urandom, $urandom},
            8'($urandom), 9'h100);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(2, 1, 1, 32'(BASE) + 32'(i * 8), 0, 8'hFF, 9'(1) << i);
      tick();
    end
    idle_all();
    repeat (4) tick();

    // Out-of-range read on every latency.
    for (int k = 0; k < 3; k++) drive(k, 1, 1, 32'h1C02_0000, 0, 8'hFF, 9'h080);
    tick();
    idle_all();
    repeat (4) tick();

    // Sleep with two reads in flight, latency 2.
    drive(1, 1, 1, 32'(BASE), 0, 8'hFF, 9'h001);
    tick();
    drive(1, 1, 1, 32'(BASE) + 32'd8, 0, 8'hFF, 9'h002);
    tick();
    sreq[1] = 1'b1;
    drive(1, 1, 1, 32'(BASE) + 32'd16, 0, 8'hFF, 9'h004);
    repeat (6) tick();
    sreq[1] = 1'b0;
    repeat (3) tick();
    idle_all();
    tick();

    // Sleep with empty pipeline: one-cycle drain.
    sreq[0] = 1'b1;
    repeat (3) tick();
    sreq[0] = 1'b0;
    repeat (2) tick();

    // Random traffic with occasional sleep requests.
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < 3; k++) begin
        drive(k, $urandom_range(0, 3) != 0, 1'($urandom), rand_addr(),
              {$urandom, $urandom}, 8'($urandom), 9'(1) << $urandom_range(0, 8));
        if ($urandom_range(0, 15) == 0) sreq[k] = ~sreq[k];
      end
      tick();
    end
    idle_all();
    for (int k = 0; k < 3; k++) sreq[k] = 1'b0;
    repeat (4) tick();

    // Reset with responses in flight, latency 3.
    drive(2, 1, 1, 32'(BASE), 0, 8'hFF, 9'h008);
    tick();
    drive(2, 1, 1, 32'(BASE) + 32'd8, 0, 8'hFF, 9'h020);
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle_all();
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
